// File: rtl/bench_bist_ctrl_if.sv
// bench_bist_ctrl_if: host config/result and benchmark pattern bus of the BIST sequencer
interface bench_bist_ctrl_if #(parameter int IN_W = 157, parameter int OUT_W = 64) ();
  logic start;
  logic abort;
  logic [15:0] num_patterns;
  logic [31:0] seed;
  logic [OUT_W-1:0] golden_sig;
  logic [IN_W-1:0] dut_in;
  logic [OUT_W-1:0] dut_out;
  logic busy;
  logic done;
  logic pass;
  logic [OUT_W-1:0] signature;
  logic [15:0] pattern_idx;
  modport master (
    output start, abort, num_patterns, seed, golden_sig, dut_out,
    input dut_in, busy, done, pass, signature, pattern_idx
  );
  modport slave (
    input start, abort, num_patterns, seed, golden_sig, dut_out,
    output dut_in, busy, done, pass, signature, pattern_idx
  );
endinterface

// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl: LFSR pattern generator and MISR compactor with golden-signature verdict
module bench_bist_ctrl #(
  parameter int IN_W = 157,
  parameter int OUT_W = 64,
  parameter int SETTLE_CYCLES = 2,
  parameter logic [OUT_W-1:0] MISR_POLY = 64'h000000000000001B,
  parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
  input logic clk,
  input logic rst_n,
  bench_bist_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GEN, SETTLE, CAPTURE, DONE} state_t;
  state_t state, nxt;
  logic [31:0] lfsr, lfsr_nx;
  logic [15:0] cnt, num, idx;
  logic [OUT_W-1:0] gold, sig, sig_nx;
  logic [IN_W-1:0] din;
  logic pass, last, settle_last, go;
  assign lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 32'd0);
  assign sig_nx = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : '0) ^ bus.dut_out;
  assign last = idx == num - 16'd1;
  assign settle_last = cnt == 16'(SETTLE_CYCLES - 1);
  assign go = (state == IDLE || state == DONE) && bus.start;
  assign bus.dut_in = din;
  assign bus.busy = state == GEN || state == SETTLE || state == CAPTURE;
  assign bus.done = state == DONE;
  assign bus.pass = pass;
  assign bus.signature = sig;
  assign bus.pattern_idx = idx;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (bus.abort) nxt = IDLE;
    else if (go) nxt = bus.num_patterns == 16'd0 ? DONE : GEN;
    else if (state == GEN) nxt = SETTLE_CYCLES == 0 ? CAPTURE : SETTLE;
    else if (state == SETTLE) nxt = settle_last ? CAPTURE : SETTLE;
    else if (state == CAPTURE) nxt = last ? DONE : GEN;
  end
  // abort keeps signature/pattern_idx/dut_in visible for post-mortem debug
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= 32'd1;
      cnt <= '0;
      num <= '0;
      idx <= '0;
      gold <= '0;
      sig <= '0;
      din <= '0;
      pass <= 1'b0;
    end else if (bus.abort) begin
      pass <= 1'b0;
    end else if (go) begin
      num <= bus.num_patterns;
      gold <= bus.golden_sig;
      lfsr <= bus.seed == 32'd0 ? 32'd1 : bus.seed;
      cnt <= '0;
      idx <= '0;
      sig <= '0;
      din <= '0;
      pass <= bus.num_patterns == 16'd0 && bus.golden_sig == '0;
    end else if (state == GEN) begin
      lfsr <= lfsr_nx;
      din <= {din[IN_W-33:0], lfsr_nx};
      cnt <= '0;
    end else if (state == SETTLE) begin
      cnt <= cnt + 16'd1;
    end else if (state == CAPTURE) begin
      sig <= sig_nx;
      idx <= idx + 16'd1;
      pass <= last && sig_nx == gold;
    end
  end
endmodule

// File: tb/tb_bench_bist_ctrl.sv
// tb_bench_bist_ctrl: loopback scoreboard bench for the BIST sequencer
module tb_bench_bist_ctrl;
  typedef struct {
    logic [63:0] sig;
    logic pass;
    int idx;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  logic [156:0] pat_q[$];
  logic [63:0] sig_a;
  bench_bist_ctrl_if #(.IN_W(157), .OUT_W(64)) bus ();
  bench_bist_ctrl #(.IN_W(157), .OUT_W(64), .SETTLE_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.dut_out = bus.dut_in[63:0];
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run(input int n, input logic [31:0] sd, input logic [63:0] gold, input int abort_at, input bit glitch);
    exp_t e;
    logic [31:0] l;
    logic [156:0] d;
    logic [63:0] s;
    logic [15:0] pidx;
    int lat;
    l = sd == 32'd0 ? 32'd1 : sd;
    d = '0;
    s = '0;
    for (int i = 0; i < n; i++) begin
      l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'd0);
      d = {d[124:0], l};
      s = {s[62:0], 1'b0} ^ (s[63] ? 64'h1B : 64'd0) ^ d[63:0];
      pat_q.push_back(d);
    end
    e.sig = s;
    e.pass = s == gold;
    e.idx = n;
    e.lat = n * 4;
    exp_q.push_back(e);
    bus.num_patterns = 16'(n);
    bus.seed = sd;
    bus.golden_sig = gold;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    chk("idx_clr", bus.pattern_idx, 0);
    chk("done_at_start", bus.done, n == 0);
    chk("busy_at_start", bus.busy, n != 0);
    pidx = 16'd0;
    lat = 0;
    while (!bus.done && lat < n * 4 + 20) begin
      if (abort_at >= 0 && int'(bus.pattern_idx) == abort_at) begin
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_pass", bus.pass, 0);
        chk("abort_idx", bus.pattern_idx, abort_at);
        tick;
        chk("abort_stays_idle", bus.busy, 0);
        void'(exp_q.pop_front());
        pat_q.delete();
        return;
      end
      if (glitch && lat == 1) begin
        bus.start = 1'b1;
        bus.num_patterns = 16'd9;
      end
      tick;
      lat++;
      bus.start = 1'b0;
      if (bus.pattern_idx != pidx) begin
        pidx = bus.pattern_idx;
        chk("pattern", bus.dut_in, pat_q.pop_front());
      end
    end
    if (!bus.done) begin
      chk("timeout", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk("sig", bus.signature, e.sig);
    chk("pass", bus.pass, e.pass);
    chk("idx_done", bus.pattern_idx, e.idx);
    chk("latency", lat, e.lat);
    chk("busy_done", bus.busy, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_patterns = '0;
    bus.seed = '0;
    bus.golden_sig = '0;
    tick;
    tick;
    rst_n = 1'b1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sig", bus.signature, 0);
    chk("rst_din", bus.dut_in, 0);
    bus.num_patterns = 16'd1;
    bus.seed = 32'd1;
    bus.golden_sig = 64'h80200003;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    chk("first_pattern", bus.dut_in, 157'h80200003);
    repeat (5) tick;
    run(1, 32'd1, 64'h80200003, -1, 1'b0);
    chk("one_sig", bus.signature, 64'h0000000080200003);
    chk("one_pass", bus.pass, 1);
    run(1, 32'd1, 64'd0, -1, 1'b0);
    chk("one_fail", bus.pass, 0);
    run(0, 32'd5, 64'd0, -1, 1'b0);
    chk("zero_sig", bus.signature, 0);
    run(0, 32'd5, 64'd3, -1, 1'b0);
    chk("zero_pass_bad_gold", bus.pass, 0);
    run(8, 32'd0, 64'd0, -1, 1'b0);
    sig_a = bus.signature;
    run(8, 32'd1, 64'd0, -1, 1'b0);
    chk("seed0_eq_seed1", bus.signature, sig_a);
    run(100, 32'hDEADBEEF, 64'd0, 10, 1'b0);
    run(3, 32'h1234, 64'd0, -1, 1'b0);
    run(4, 32'hCAFE0001, 64'd0, -1, 1'b1);
    sig_a = bus.signature;
    run(4, 32'hCAFE0001, sig_a, -1, 1'b0);
    chk("repeat_sig", bus.signature, sig_a);
    chk("repeat_pass", bus.pass, 1);
    run(20, 32'h0BADF00D, 64'd0, -1, 1'b0);
    bus.num_patterns = 16'd50;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (9) tick;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_pass", bus.pass, 0);
    chk("midrst_sig", bus.signature, 0);
    chk("midrst_idx", bus.pattern_idx, 0);
    chk("midrst_din", bus.dut_in, 0);
    run(2, 32'd7, 64'd0, -1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
